riscv_main_fsm: RTL

- Main control state machine for the multicycle RISC-V datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables.
- Produces the 2-bit ALUOp consumed by the ALU decoder, which sits directly downstream of this block.
- Supports lw, sw, R-type, I-type ALU, beq and jal, and waits on a memory ready handshake.

---
 rtl/riscv_main_fsm.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/riscv_main_fsm.sv
// Main control FSM for the multicycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module riscv_main_fsm #(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);

    logic [3:0] state;
    logic [3:0] state_nx;
    logic       pc_update;
    logic       branch;
    logic       ir_wr_c;
    logic       mem_wr_c;
    logic       reg_wr_c;
    logic       illegal_c;

    // State register; reset parks the machine in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection, including opcode dispatch in DECODE.
    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:    state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (op == OP_LW),
                    (op == OP_SW):  state_nx = S_MEMADR;
                    (op == OP_R):   state_nx = S_EXECUTER;
                    (op == OP_I):   state_nx = S_EXECUTEI;
                    (op == OP_BEQ): state_nx = S_BEQ;
                    (op == OP_JAL): state_nx = S_JAL;
                    default:        state_nx = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nx = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nx = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWRITE: state_nx = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_nx = S_ALUWB;
            S_EXECUTEI: state_nx = S_ALUWB;
            S_ALUWB:    state_nx = S_FETCH;
            S_BEQ:      state_nx = S_FETCH;
            S_JAL:      state_nx = S_ALUWB;
            default:    state_nx = S_FETCH;
        endcase
    end

    // Per-state datapath controls; unlisted controls stay at 0.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        ir_wr_c    = 1'b0;
        mem_wr_c   = 1'b0;
        reg_wr_c   = 1'b0;
        illegal_c  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_wr_c    = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal_c = !((op == OP_LW) || (op == OP_SW) ||
                              (op == OP_R) || (op == OP_I) ||
                              (op == OP_BEQ) || (op == OP_JAL));
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_wr_c   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src  = 1'b1;
                mem_wr_c = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_wr_c = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    // Enables are masked by reset so nothing writes during assertion.
    always_comb begin
        pc_write   = rst_n & (pc_update | (branch & zero));
        ir_write   = rst_n & ir_wr_c;
        mem_write  = rst_n & mem_wr_c;
        reg_write  = rst_n & reg_wr_c;
        illegal_op = rst_n & illegal_c;
        state_o    = STATE_W'(state);
    end

endmodule
